// File: rtl/uart_param_core.sv
// UART core: runtime baud divisor, oversampled RX, elaboration-time frame format.
// TX accepts on tx_data_valid && tx_ready (start bit next edge); RX has no backpressure, 1-cycle pulses.
module uart_param_core #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 tx_data_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 sout,
  output logic                 tx_busy,
  input  logic                 sin,
  output logic                 rx_data_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_busy,
  output logic                 rx_parity_error,
  output logic                 rx_frame_error
);
  localparam bit HAS_PAR = (PARITY_MODE != 0);
  localparam bit ODD     = (PARITY_MODE == 1);
  localparam int TW      = $clog2(OVERSAMPLE + 1);
  localparam int BW      = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_state, tx_next;
  logic [DIV_WIDTH-1:0] tx_div, tx_div_cnt;
  logic [TW-1:0]        tx_tick_cnt;
  logic [BW-1:0]        tx_bit_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_stop_cnt;
  logic                 tx_bit_end, tx_last_data, tx_last_stop;

  assign tx_ready     = (tx_state == IDLE);
  assign tx_busy      = !tx_ready;
  assign tx_bit_end   = (tx_div_cnt == tx_div) && (tx_tick_cnt == TW'(OVERSAMPLE - 1));
  assign tx_last_data = (tx_bit_cnt == BW'(DATA_BITS - 1));
  assign tx_last_stop = (tx_stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state <= IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:    if (tx_data_valid) tx_next = START;
      START:   if (tx_bit_end) tx_next = DATA;
      DATA:    if (tx_bit_end && tx_last_data) tx_next = HAS_PAR ? PARITY : STOP;
      PARITY:  if (tx_bit_end) tx_next = STOP;
      STOP:    if (tx_bit_end && tx_last_stop) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sout        <= 1'b1;
      tx_div      <= '0;
      tx_div_cnt  <= '0;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_stop_cnt <= 1'b0;
    end else begin
      // Bit timer is held at zero while idle so each frame starts a fresh period.
      if (tx_state == IDLE || tx_bit_end) begin
        tx_div_cnt  <= '0;
        tx_tick_cnt <= '0;
      end else if (tx_div_cnt == tx_div) begin
        tx_div_cnt  <= '0;
        tx_tick_cnt <= tx_tick_cnt + 1'b1;
      end else begin
        tx_div_cnt  <= tx_div_cnt + 1'b1;
      end
      case (tx_state)
        IDLE: begin
          sout <= !tx_data_valid;
          if (tx_data_valid) begin
            tx_shift    <= tx_data;
            tx_par      <= (^tx_data) ^ ODD;
            tx_div      <= baud_div;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
          end
        end
        START: if (tx_bit_end) sout <= tx_shift[0];
        DATA: if (tx_bit_end) begin
          tx_bit_cnt <= tx_bit_cnt + 1'b1;
          tx_shift   <= tx_shift >> 1;
          sout       <= tx_last_data ? (HAS_PAR ? tx_par : 1'b1) : tx_shift[1];
        end
        PARITY: if (tx_bit_end) sout <= 1'b1;
        STOP:   if (tx_bit_end) tx_stop_cnt <= tx_stop_cnt + 1'b1;
        default: sout <= 1'b1;
      endcase
    end
  end

  // ---------------- receiver ----------------
  state_t               rx_state, rx_next;
  logic                 sync1, sync2;
  logic [DIV_WIDTH-1:0] rx_div, rx_div_cnt;
  logic [TW-1:0]        rx_tick_cnt;
  logic [BW-1:0]        rx_bit_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_stop_cnt, rx_perr, rx_ferr;
  logic                 rx_sample, rx_last_data, rx_last_stop, rx_timing;

  assign rx_busy      = (rx_state != IDLE);
  assign rx_timing    = (rx_state != IDLE) && (rx_state != WAIT_HIGH);
  assign rx_last_data = (rx_bit_cnt == BW'(DATA_BITS - 1));
  assign rx_last_stop = (rx_stop_cnt == 1'(STOP_BITS - 1));
  // First sample lands half a bit after the falling edge, later ones a full bit apart.
  assign rx_sample    = rx_timing && (rx_div_cnt == rx_div) &&
                        (rx_tick_cnt == ((rx_state == START) ? TW'(OVERSAMPLE / 2 - 1)
                                                             : TW'(OVERSAMPLE - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) rx_state <= IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:      if (!sync2) rx_next = START;
      START:     if (rx_sample) rx_next = sync2 ? IDLE : DATA;
      DATA:      if (rx_sample && rx_last_data) rx_next = HAS_PAR ? PARITY : STOP;
      PARITY:    if (rx_sample) rx_next = STOP;
      STOP:      if (rx_sample && rx_last_stop) rx_next = (rx_ferr || !sync2) ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (sync2) rx_next = IDLE;
      default:   rx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1           <= 1'b1;
      sync2           <= 1'b1;
      rx_div          <= '0;
      rx_div_cnt      <= '0;
      rx_tick_cnt     <= '0;
      rx_bit_cnt      <= '0;
      rx_shift        <= '0;
      rx_stop_cnt     <= 1'b0;
      rx_perr         <= 1'b0;
      rx_ferr         <= 1'b0;
      rx_data         <= '0;
      rx_data_valid   <= 1'b0;
      rx_parity_error <= 1'b0;
      rx_frame_error  <= 1'b0;
    end else begin
      sync1           <= sin;
      sync2           <= sync1;
      rx_data_valid   <= 1'b0;
      rx_parity_error <= 1'b0;
      rx_frame_error  <= 1'b0;
      if (!rx_timing || rx_sample) begin
        rx_div_cnt  <= '0;
        rx_tick_cnt <= '0;
      end else if (rx_div_cnt == rx_div) begin
        rx_div_cnt  <= '0;
        rx_tick_cnt <= rx_tick_cnt + 1'b1;
      end else begin
        rx_div_cnt  <= rx_div_cnt + 1'b1;
      end
      case (rx_state)
        IDLE: if (!sync2) begin
          rx_div      <= baud_div;
          rx_bit_cnt  <= '0;
          rx_stop_cnt <= 1'b0;
          rx_perr     <= 1'b0;
          rx_ferr     <= 1'b0;
        end
        DATA: if (rx_sample) begin
          rx_shift   <= {sync2, rx_shift[DATA_BITS-1:1]};
          rx_bit_cnt <= rx_bit_cnt + 1'b1;
        end
        PARITY: if (rx_sample) rx_perr <= (sync2 != ((^rx_shift) ^ ODD));
        STOP: if (rx_sample) begin
          rx_stop_cnt <= rx_stop_cnt + 1'b1;
          rx_ferr     <= rx_ferr | !sync2;
          if (rx_last_stop) begin
            rx_data         <= rx_shift;
            rx_data_valid   <= 1'b1;
            rx_parity_error <= rx_perr;
            rx_frame_error  <= rx_ferr | !sync2;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: 8E1, 16x oversampling; RX results checked through an expected-frame queue.
`timescale 1ns/1ps
module tb_uart_param_core;
  localparam int DB = 8, PM = 2, SB = 1, OS = 16, DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] baud_div = '0;
  logic          tx_data_valid = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_ready, sout, tx_busy;
  logic          rx_data_valid, rx_busy, rx_parity_error, rx_frame_error;
  logic [DB-1:0] rx_data;
  logic          sin_drv = 1'b1, loop_en = 1'b0, sin;

  assign sin = loop_en ? sout : sin_drv;

  int n_checks = 0, n_pass = 0, cyc = 0, rx_pulses = 0;

  typedef struct packed {logic [DB-1:0] data; logic perr; logic ferr;} rx_exp_t;
  rx_exp_t exp_q[$];

  uart_param_core #(.DATA_BITS(DB), .PARITY_MODE(PM), .STOP_BITS(SB),
                    .OVERSAMPLE(OS), .DIV_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data_valid(tx_data_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .sout(sout), .tx_busy(tx_busy), .sin(sin),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data), .rx_busy(rx_busy),
    .rx_parity_error(rx_parity_error), .rx_frame_error(rx_frame_error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every RX pulse must match the next expected frame.
  always @(negedge clk) begin
    if (rx_data_valid) begin
      rx_exp_t e;
      rx_pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_unexpected: data=%h perr=%b ferr=%b, required no pulse",
                 rx_data, rx_parity_error, rx_frame_error);
      end else begin
        e = exp_q.pop_front();
        if ({rx_data, rx_parity_error, rx_frame_error} !== e)
          $display("FAIL rx_frame: data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   rx_data, rx_parity_error, rx_frame_error, e.data, e.perr, e.ferr);
        else n_pass++;
      end
    end
  end

  task automatic drive_frame(input logic [DB-1:0] d, input logic par, input logic stp);
    int bp = OS * (int'(baud_div) + 1);
    sin_drv = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      sin_drv = d[i];
      repeat (bp) @(negedge clk);
    end
    sin_drv = par;
    repeat (bp) @(negedge clk);
    sin_drv = stp;
    repeat (bp) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (sout !== 1'b1) $display("FAIL reset_sout: got %b, required 1", sout); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b, required 0", tx_busy); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL reset_rx_busy: got %b, required 0", rx_busy); else n_pass++;
    n_checks++;
    if ({rx_data_valid, rx_parity_error, rx_frame_error} !== 3'b000)
      $display("FAIL reset_rx_pulses: got %b, required 000", {rx_data_valid, rx_parity_error, rx_frame_error});
    else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h, required 00", rx_data); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_a5();
    logic [7:0]  d;
    logic [10:0] bits;
    int          ready_hi = 0;
    d = 8'hA5;
    bits = {1'b1, ^d, d, 1'b0};
    baud_div = 0;
    tx_data = d;
    tx_data_valid = 1'b1;
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      if (k == 0) tx_data_valid = 1'b0;
      if (tx_ready) ready_hi++;
      if (k % 16 == 0 || k % 16 == 15) begin
        n_checks++;
        if (sout !== bits[k/16]) $display("FAIL tx_a5_bit%0d_c%0d: got %b, required %b", k/16, k%16, sout, bits[k/16]);
        else n_pass++;
      end
    end
    n_checks++; if (ready_hi != 0) $display("FAIL tx_a5_ready_low: high for %0d cycles, required 0", ready_hi); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL tx_a5_ready_177: got %b, required 1", tx_ready); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int acc [3];
    int p0, w;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    baud_div = 3;
    loop_en = 1'b1;
    repeat (5) @(negedge clk);
    p0 = rx_pulses;
    for (int b = 0; b < 3; b++) exp_q.push_back({bytes[b], 1'b0, 1'b0});
    tx_data_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tx_data = bytes[b];
      w = 0;
      while (!tx_ready && w < 3000) begin @(negedge clk); w++; end
      acc[b] = cyc + 1;
      @(negedge clk);
    end
    tx_data_valid = 1'b0;
    for (int b = 1; b < 3; b++) begin
      n_checks++;
      if (acc[b] - acc[b-1] != 705) $display("FAIL b2b_accept_gap%0d: got %0d cycles, required 705", b, acc[b] - acc[b-1]);
      else n_pass++;
    end
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin @(negedge clk); w++; end
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d frames outstanding, required 0", exp_q.size()); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_pulses - p0 != 3) $display("FAIL b2b_pulses: got %0d, required 3", rx_pulses - p0); else n_pass++;
    n_checks++; if (rx_data !== 8'h3C) $display("FAIL b2b_rx_hold: got %h, required 3c", rx_data); else n_pass++;
    w = 0;
    while (!tx_ready && w < 3000) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    loop_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_parity_error();
    int p0, w;
    baud_div = 0;
    p0 = rx_pulses;
    exp_q.push_back({8'h5A, 1'b1, 1'b0});
    drive_frame(8'h5A, 1'b1, 1'b1);
    sin_drv = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    n_checks++; if (rx_pulses - p0 != 1) $display("FAIL perr_pulses: got %0d, required 1", rx_pulses - p0); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL perr_idle: rx_busy=%b, required 0", rx_busy); else n_pass++;
  endtask

  task automatic test_frame_error();
    int p0;
    baud_div = 0;
    p0 = rx_pulses;
    exp_q.push_back({8'h33, 1'b0, 1'b1});
    drive_frame(8'h33, 1'b0, 1'b0);
    repeat (40 * OS) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL ferr_break_busy: got %b, required 1", rx_busy); else n_pass++;
    n_checks++; if (rx_pulses - p0 != 1) $display("FAIL ferr_pulses: got %0d, required 1", rx_pulses - p0); else n_pass++;
    sin_drv = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL ferr_release: rx_busy=%b, required 0", rx_busy); else n_pass++;
    repeat (100) @(negedge clk);
    n_checks++; if (rx_pulses - p0 != 1) $display("FAIL ferr_no_extra: got %0d pulses, required 1", rx_pulses - p0); else n_pass++;
  endtask

  task automatic test_false_start();
    int p0, busy = 0;
    baud_div = 0;
    p0 = rx_pulses;
    for (int k = 0; k < 50; k++) begin
      sin_drv = (k < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (rx_busy) busy++;
    end
    n_checks++; if (busy != 8) $display("FAIL glitch_busy: busy %0d cycles, required 8", busy); else n_pass++;
    n_checks++; if (rx_pulses != p0) $display("FAIL glitch_pulse: got %0d pulses, required 0", rx_pulses - p0); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int p0;
    logic [7:0]  d;
    logic [10:0] bits;
    baud_div = 0;
    p0 = rx_pulses;
    tx_data = 8'h55;
    tx_data_valid = 1'b1;
    sin_drv = 1'b0;
    @(negedge clk);
    tx_data_valid = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++; if ({tx_busy, rx_busy} !== 2'b11) $display("FAIL abort_pre_busy: got %b, required 11", {tx_busy, rx_busy}); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (sout !== 1'b1) $display("FAIL abort_sout: got %b, required 1", sout); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL abort_tx_ready: got %b, required 1", tx_ready); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL abort_rx_busy: got %b, required 0", rx_busy); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL abort_rx_data: got %h, required 00", rx_data); else n_pass++;
    sin_drv = 1'b1;
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++; if (rx_pulses != p0) $display("FAIL abort_no_pulse: got %0d pulses, required 0", rx_pulses - p0); else n_pass++;
    d = 8'h81;
    bits = {1'b1, ^d, d, 1'b0};
    tx_data = d;
    tx_data_valid = 1'b1;
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      if (k == 0) tx_data_valid = 1'b0;
      if (k % 16 == 8) begin
        n_checks++;
        if (sout !== bits[k/16]) $display("FAIL abort_tx81_bit%0d: got %b, required %b", k/16, sout, bits[k/16]);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL abort_tx81_done: tx_ready=%b, required 1", tx_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_a5();
    test_back_to_back();
    test_parity_error();
    test_frame_error();
    test_false_start();
    test_reset_abort();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
Parametrised single-clock UART core for the FPGA serial path. It replaces the fixed-format transmitter/receiver pair and the shared serial clock generator with two things: per-direction bit timers driven by a runtime baud divisor, and 16x-class oversampled reception. Frame format is set at elaboration time: data width, parity mode and stop-bit count. It also adds a valid/ready TX handshake, an RX input synchroniser, false-start rejection, and separate parity and framing error reporting.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent and received LSB first
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, legal 1 or 2
OVERSAMPLE, 16, oversample ticks per bit, even, legal >= 4
DIV_WIDTH, 16, width of baud_div

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
baud_div  input  DIV_WIDTH  clk cycles per oversample tick minus 1
tx_data_valid  input  1  TX byte offered
tx_data  input  DATA_BITS  TX payload
tx_ready  output  1  core can accept a TX byte
sout  output  1  serial out, idle high
tx_busy  output  1  frame being transmitted
sin  input  1  asynchronous serial in
rx_data_valid  output  1  one-cycle pulse, rx_data valid
rx_data  output  DATA_BITS  last received payload
rx_busy  output  1  receiver inside a frame
rx_parity_error  output  1  one-cycle pulse with rx_data_valid
rx_frame_error  output  1  one-cycle pulse with rx_data_valid

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset values: sout=1, tx_ready=1, tx_busy=0, rx_busy=0, rx_data_valid=0, rx_parity_error=0, rx_frame_error=0, rx_data=0. Both state machines go to IDLE and the synchroniser flops are set to 1.
- Bit period = OVERSAMPLE*(baud_div+1) clk cycles.
- baud_div is latched at frame start: TX on accept, RX on start detect. Changes mid-frame have no effect on the current frame.
- TX state machine, states IDLE -> START -> DATA -> PARITY (skipped if PARITY_MODE=0) -> STOP -> IDLE.
  - tx_ready = (state==IDLE). tx_busy = !tx_ready.
  - Accept when tx_data_valid && tx_ready: latch tx_data, and sout goes 0 on the next clk edge.
  - Each bit is held exactly one bit period. The timer restarts on accept.
  - Parity bit = XOR of the data bits, inverted for odd mode.
  - STOP drives 1 for STOP_BITS bit periods. tx_ready rises in the cycle after the last stop period ends.
  - Total frame = (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS) bit periods.
  - tx_data_valid while busy is ignored; the holder must keep it asserted until the handshake.
- RX input: sin passes through a 2-flop synchroniser (2 cycles latency). All RX decisions use the synchronised value.
- RX state machine, states IDLE -> START -> DATA -> PARITY (optional) -> STOP -> (WAIT_HIGH) -> IDLE.
  - IDLE: on synchronised sin==0, enter START and restart the prescaler.
  - START: after OVERSAMPLE/2 ticks, re-sample. If 1, it is a false start: return to IDLE with no pulses. If 0, go to DATA.
  - Each subsequent sample is taken OVERSAMPLE ticks after the previous one, i.e. at bit centre.
  - Data is shifted in LSB first. Received parity is checked against the computed parity.
  - STOP: sample STOP_BITS centres. Framing error if any stop sample is 0.
  - One clk after the final stop sample: rx_data_valid=1 for one cycle, rx_data updated. rx_parity_error and rx_frame_error pulse in the same cycle if applicable. Data is delivered even on error.
  - After a frame error, go to WAIT_HIGH until synchronised sin==1, then IDLE. This covers line breaks.
  - rx_busy = (state!=IDLE).
- RX has no backpressure: the consumer must capture rx_data on the pulse. rx_data holds until the next valid pulse.
- TX and RX are fully independent; simultaneous activity is legal.
- rst_n low mid-frame aborts immediately: sout=1 on the next edge, and no rx pulse is emitted.

Test Plan:
- DATA_BITS=8, PARITY_MODE=2, STOP_BITS=1, OVERSAMPLE=16, baud_div=0; send 0xA5 -> sout = 0,1,0,1,0,0,1,0,1,0(parity),1, each held 16 clk. tx_ready low for 176 cycles, high at cycle 177 after accept.
- Loopback sout->sin, same config, baud_div=3, bytes 0x00, 0xFF, 0x3C back-to-back -> three rx_data_valid pulses with matching rx_data, no error pulses. Second accept occurs the cycle tx_ready rises.
- Drive sin with 0x5A frame carrying parity bit 1 under even mode -> rx_data=0x5A, rx_parity_error pulses with rx_data_valid, rx_frame_error=0.
- Drive 0x33 frame with stop bit 0, then hold sin low 40 bit periods -> one valid pulse with rx_frame_error=1, rx_busy high until sin returns high, no further pulses.
- sin low glitch of 4 clk (baud_div=0) -> no rx_data_valid; rx_busy returns low 8 ticks after detect.
- Assert rst_n low in DATA phase of a TX frame and an RX frame -> next edge sout=1, tx_ready=1, rx_busy=0, no rx pulse. A fresh 0x81 then transmits correctly.
